spi_frame_ctrl: RTL and testbench

Control stage directly upstream of the SPI front-end (SIPO/PISO/PIPO chain plus data mux). It accepts a serial message stream through a valid/ready handshake and produces the shift strobe, the single-cycle load pulse and the mux select for that stage. Once a K-bit frame is captured, it issues the K/(M·La) message chunks to the encoder under a valid/ready handshake. Filling of the next frame overlaps chunk issue of the current one.

---
 rtl/spi_frame_ctrl_pkg.sv | 22 ++
 rtl/spi_frame_ctrl_if.sv | 39 +++
 rtl/spi_frame_ctrl_chunk_sequencer.sv | 57 +++++
 rtl/spi_frame_ctrl.sv | 105 ++++++++++
 tb/tb_spi_frame_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/spi_frame_ctrl_pkg.sv
// Shared constants and state encodings for the SPI front-end control stage.
// N_CHUNK must equal 2**SEL_W so that f_sel wraps exactly at the last chunk.
package spi_ctrl_pkg;

    localparam int K       = 1024;
    localparam int M       = 32;
    localparam int La      = 8;
    localparam int N_CHUNK = K / (M * La);
    localparam int SEL_W   = 2;
    localparam int FILL_W  = $clog2(K);

    typedef enum logic {
        FILL = 1'b0,
        LOAD = 1'b1
    } fill_state_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } issue_state_t;

endpackage

// File: rtl/spi_frame_ctrl_if.sv
// Bundle between the serial source / encoder side and the frame controller.
// Optional frame_cnt/stall_cnt exist only with SPI_CTRL_FRAME_CNT_EN.
interface spi_frame_ctrl_if;
    import spi_ctrl_pkg::*;

    logic             ser_in;
    logic             ser_valid;
    logic             ser_ready;
    logic             sm_in;
    logic             in;
    logic             datavalid;
    logic             en;
    logic             sm;
    logic [SEL_W-1:0] f_sel;
    logic             chunk_valid;
    logic             chunk_ready;
    logic             busy;
`ifdef SPI_CTRL_FRAME_CNT_EN
    logic [15:0]      frame_cnt;
    logic [15:0]      stall_cnt;
`endif

    modport master (
        output ser_in, ser_valid, sm_in, chunk_ready,
        input  ser_ready, in, datavalid, en, sm, f_sel, chunk_valid, busy
`ifdef SPI_CTRL_FRAME_CNT_EN
        , input frame_cnt, stall_cnt
`endif
    );

    modport slave (
        input  ser_in, ser_valid, sm_in, chunk_ready,
        output ser_ready, in, datavalid, en, sm, f_sel, chunk_valid, busy
`ifdef SPI_CTRL_FRAME_CNT_EN
        , output frame_cnt, stall_cnt
`endif
    );

endinterface

// File: rtl/spi_frame_ctrl_chunk_sequencer.sv
// Issues the N_CHUNK chunk selects of one captured frame to the encoder.
// Latency: chunk_valid the cycle after start; one chunk per cycle at best.
// Backpressure: f_sel/chunk_valid hold while chunk_ready is low.
module chunk_sequencer
    import spi_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             chunk_ready,
    output logic [SEL_W-1:0] f_sel,
    output logic             chunk_valid,
    output logic             idle
);

    issue_state_t     state_q, state_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        chunk_valid = (state_q == ISSUE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    cnt_d   = '0;
                end
            end
            ISSUE: begin
                if (chunk_ready) begin
                    if (cnt_q == SEL_W'(N_CHUNK - 1)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign f_sel = cnt_q;
    assign idle  = (state_q == IDLE);

endmodule

// File: rtl/spi_frame_ctrl.sv
// Serial-to-frame control for the SPI front-end; optional counters via SPI_CTRL_FRAME_CNT_EN.
// Latency: K-th bit accepted at edge n -> en in cycle n+1, chunk_valid in cycle n+2.
// Backpressure: ser_ready drops in LOAD and on the K-th bit while the previous frame still issues.
module spi_frame_ctrl
    import spi_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    spi_frame_ctrl_if.slave bus
);

    fill_state_t       fill_q, fill_d;
    logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
    logic              rdy_arm_q;
    logic              sm_q;
    logic              rdy_w;
    logic              en_w;
    logic              seq_idle;
    logic              last_bit;

    assign last_bit = (fill_cnt_q == FILL_W'(K - 1));

    // rdy_arm_q keeps ser_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_q     <= FILL;
            fill_cnt_q <= '0;
            rdy_arm_q  <= 1'b0;
            sm_q       <= 1'b0;
        end else begin
            fill_q     <= fill_d;
            fill_cnt_q <= fill_cnt_d;
            rdy_arm_q  <= 1'b1;
            if (fill_q == LOAD) begin
                sm_q <= bus.sm_in;
            end
        end
    end

    // The stall uses the registered issue state, so a frame can never load mid-issue
    always_comb begin
        fill_d     = fill_q;
        fill_cnt_d = fill_cnt_q;
        rdy_w      = 1'b0;
        en_w       = 1'b0;
        case (fill_q)
            FILL: begin
                rdy_w = rdy_arm_q & ~(last_bit & ~seq_idle);
                if (bus.ser_valid && rdy_w) begin
                    if (last_bit) begin
                        fill_cnt_d = '0;
                        fill_d     = LOAD;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 1'b1;
                    end
                end
            end
            LOAD: begin
                en_w   = 1'b1;
                fill_d = FILL;
            end
            default: fill_d = FILL;
        endcase
    end

    chunk_sequencer u_seq (
        .clk         (clk),
        .rst         (rst),
        .start       (en_w),
        .chunk_ready (bus.chunk_ready),
        .f_sel       (bus.f_sel),
        .chunk_valid (bus.chunk_valid),
        .idle        (seq_idle)
    );

    assign bus.ser_ready = rdy_w;
    assign bus.in        = bus.ser_in;
    assign bus.datavalid = bus.ser_valid & rdy_w;
    assign bus.en        = en_w;
    assign bus.sm        = sm_q;
    assign bus.busy      = ~seq_idle | (fill_q == LOAD);

`ifdef SPI_CTRL_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (en_w) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (bus.ser_valid && !rdy_w) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl: fill, issue, stall, toggled valid, mid-frame reset.
module tb_spi_frame_ctrl;
    import spi_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    spi_frame_ctrl_if bus();

    spi_frame_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Streams bits until n are accepted (bounded); ends with ser_valid low.
    task automatic send_bits(input int n, input bit toggle,
                             output int cycles, output int en_seen, output int dv_err);
        int acc;
        acc = 0; cycles = 0; en_seen = 0; dv_err = 0;
        while (acc < n && cycles < 5000) begin
            bus.ser_valid = toggle ? ~cycles[0] : 1'b1;
            bus.ser_in    = 1'($urandom);
            #1;
            if (bus.datavalid !== bus.ser_valid || bus.in !== bus.ser_in) dv_err++;
            en_seen += int'(bus.en);
            if (bus.ser_valid && bus.ser_ready) acc++;
            cyc();
            cycles++;
        end
        bus.ser_valid = 1'b0;
    endtask

    initial begin
        int cyc_n, en_n, dv_n, bad;
        bus.ser_in = 1'b0; bus.ser_valid = 1'b0; bus.sm_in = 1'b0; bus.chunk_ready = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ser_ready", bus.ser_ready, 0);
        check("rst_en", bus.en, 0);
        check("rst_sm", bus.sm, 0);
        check("rst_f_sel", bus.f_sel, 0);
        check("rst_chunk_valid", bus.chunk_valid, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b1;
        #1;
        check("ready_before_edge", bus.ser_ready, 0);
        cyc();
        check("ready_after_edge", bus.ser_ready, 1);

        // Frame 1: continuous bits, encoder always ready, sm_in high at LOAD
        bus.chunk_ready = 1'b1;
        send_bits(K, 1'b0, cyc_n, en_n, dv_n);
        check("f1_cycles", cyc_n, K);
        check("f1_en_early", en_n, 0);
        check("f1_datavalid", dv_n, 0);
        check("f1_en", bus.en, 1);
        check("f1_load_ready", bus.ser_ready, 0);
        check("f1_load_busy", bus.busy, 1);
        check("f1_load_cv", bus.chunk_valid, 0);
        bus.sm_in = 1'b1;
        cyc();
        bus.sm_in = 1'b0;
        check("f1_en_one_cycle", bus.en, 0);
        for (int i = 0; i < N_CHUNK; i++) begin
            check($sformatf("f1_fsel%0d", i), bus.f_sel, i);
            check($sformatf("f1_cv%0d", i), bus.chunk_valid, 1);
            check($sformatf("f1_sm%0d", i), bus.sm, 1);
            cyc();
        end
        check("f1_cv_done", bus.chunk_valid, 0);
        check("f1_busy_done", bus.busy, 0);
        check("f1_sm_hold", bus.sm, 1);

        // Frames A and B: encoder stalled so the K-th bit of B must wait
        bus.chunk_ready = 1'b0;
        send_bits(K, 1'b0, cyc_n, en_n, dv_n);
        check("fa_en", bus.en, 1);
        cyc();
        send_bits(K - 1, 1'b0, cyc_n, en_n, dv_n);
        check("fb_cycles", cyc_n, K - 1);
        check("fb_en_early", en_n, 0);
        check("fb_stall_ready", bus.ser_ready, 0);
        check("fb_cv", bus.chunk_valid, 1);
        check("fb_fsel", bus.f_sel, 0);
        check("fb_sm", bus.sm, 0);
        bus.ser_valid = 1'b1;
        bad = 0;
        repeat (50) begin
            if (bus.ser_ready !== 1'b0 || bus.f_sel !== 2'd0 || bus.chunk_valid !== 1'b1 ||
                bus.datavalid !== 1'b0 || bus.en !== 1'b0) bad++;
            cyc();
        end
        check("fb_hold50", bad, 0);
        bus.chunk_ready = 1'b1;
        for (int i = 0; i < N_CHUNK; i++) begin
            check($sformatf("fa_fsel%0d", i), bus.f_sel, i);
            check($sformatf("fa_stall%0d", i), bus.ser_ready, 0);
            cyc();
        end
        check("fb_ready_release", bus.ser_ready, 1);
        check("fb_cv_idle", bus.chunk_valid, 0);
        cyc();
        check("fb_en", bus.en, 1);
        bus.ser_valid = 1'b0;
        cyc();
        check("fb_issue_start", bus.chunk_valid, 1);
        repeat (4) cyc();
        check("fb_busy_done", bus.busy, 0);
`ifdef SPI_CTRL_FRAME_CNT_EN
        check("frame_cnt3", bus.frame_cnt, 3);
        check("stall_cnt54", bus.stall_cnt, 54);
`endif

        // Toggled ser_valid: 1024 accepted bits take 2047 cycles
        send_bits(K, 1'b1, cyc_n, en_n, dv_n);
        check("tg_cycles", cyc_n, 2 * K - 1);
        check("tg_en_early", en_n, 0);
        check("tg_datavalid", dv_n, 0);
        check("tg_en", bus.en, 1);
        bus.sm_in = 1'b1;
        cyc();
        bus.sm_in = 1'b0;
        repeat (5) cyc();
        check("tg_busy_done", bus.busy, 0);
        check("tg_sm", bus.sm, 1);

        // Reset in the middle of a frame discards the partial frame
        send_bits(500, 1'b0, cyc_n, en_n, dv_n);
        check("rs_cycles", cyc_n, 500);
        bus.ser_in = 1'b0;
        bus.ser_valid = 1'b1;
        rst = 1'b0;
        #1;
        check("rs_ready", bus.ser_ready, 0);
        check("rs_datavalid", bus.datavalid, 0);
        check("rs_in", bus.in, 0);
        check("rs_en", bus.en, 0);
        check("rs_sm", bus.sm, 0);
        check("rs_f_sel", bus.f_sel, 0);
        check("rs_cv", bus.chunk_valid, 0);
        check("rs_busy", bus.busy, 0);
`ifdef SPI_CTRL_FRAME_CNT_EN
        check("rs_frame_cnt", bus.frame_cnt, 0);
        check("rs_stall_cnt", bus.stall_cnt, 0);
`endif
        bus.ser_valid = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        send_bits(K - 1, 1'b0, cyc_n, en_n, dv_n);
        check("rs_en_early", en_n, 0);
        check("rs_en_not_yet", bus.en, 0);
        send_bits(1, 1'b0, cyc_n, en_n, dv_n);
        check("rs_last_cycles", cyc_n, 1);
        check("rs_en_full", bus.en, 1);
        cyc();
`ifdef SPI_CTRL_FRAME_CNT_EN
        check("rs_frame_cnt1", bus.frame_cnt, 1);
`endif
        repeat (6) cyc();
        check("rs_busy_done", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
